apb_multi_fifo: RTL and testbench

Multi-channel, APB-programmable synchronous FIFO bank. Next generation of the single-channel APB FIFO: NUM_CH independent channels, parametrised data width, per-channel runtime depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a combined interrupt. It sits as an APB4 completer. Software pushes and pops data words through a data window and configures each channel through a register window.

---
 rtl/apb_multi_fifo_pkg.sv | 30 +++
 rtl/apb_multi_fifo_ch.sv | 129 ++++++++++++
 rtl/apb_multi_fifo.sv | 154 +++++++++++++++
 tb/tb_apb_multi_fifo.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_multi_fifo_pkg.sv
// Shared register map, STATUS layout and channel control record for apb_multi_fifo.
// The depth code is kept in one place so that decode and storage use the same mapping.
package apb_multi_fifo_pkg;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_THRESH = 4'h8;

   localparam int DATA_SEL_BIT = 31;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_AF    = 2;
   localparam int ST_AE    = 3;
   localparam int ST_OVF   = 4;
   localparam int ST_UDF   = 5;

   typedef struct packed {
      logic       af_ie;
      logic       udf_ie;
      logic       ovf_ie;
      logic [3:0] code;
   } ctrl_t;

   // Code 1 selects 8 entries, and each further code doubles the depth.
   function automatic logic [15:0] depth_of(input logic [3:0] code);
      return 16'd8 << (code - 4'd1);
   endfunction

endpackage

// File: rtl/apb_multi_fifo_ch.sv
// One FIFO channel: storage, pointers that wrap at the programmed depth, thresholds and sticky flags.
// Legality of register writes is decided by the top; this block only applies them.
module apb_multi_fifo_ch
   import apb_multi_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_DEPTH = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic        ctrl_we_i,
   input  logic        status_we_i,
   input  logic        thresh_we_i,
   input  logic [31:0] wdata_i,
   output logic        full_o,
   output logic        empty_o,
   output logic        irq_o,
   output logic [31:0] head_o,
   output logic [31:0] status_o,
   output logic [31:0] ctrl_o,
   output logic [31:0] thresh_o
);
   localparam int AW = $clog2(MAX_DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [MAX_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_inc, rd_inc;
   logic [CW-1:0]    count_q, count_d, depth;
   logic [15:0]      af_lvl_q, af_lvl_d, ae_lvl_q, ae_lvl_d;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   ctrl_t            ctrl_q, ctrl_d, ctrl_new;
   logic             do_push, do_pop, almost_full, almost_empty;

   assign depth        = CW'(depth_of(ctrl_q.code));
   assign full_o       = (count_q == depth);
   assign empty_o      = (count_q == '0);
   assign almost_full  = (16'(count_q) >= af_lvl_q);
   assign almost_empty = (16'(count_q) <= ae_lvl_q);
   assign do_push      = push_i & ~full_o;
   assign do_pop       = pop_i & ~empty_o;
   assign wr_inc       = (({1'b0, wr_ptr_q} + CW'(1)) == depth) ? '0 : wr_ptr_q + AW'(1);
   assign rd_inc       = (({1'b0, rd_ptr_q} + CW'(1)) == depth) ? '0 : rd_ptr_q + AW'(1);
   assign ctrl_new     = ctrl_t'({wdata_i[18:16], wdata_i[3:0]});

   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a latch behind.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ctrl_d   = ctrl_q;
      af_lvl_d = af_lvl_q;
      ae_lvl_d = ae_lvl_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (ctrl_we_i) begin
         ctrl_d = ctrl_new;
         if (wdata_i[8] || (ctrl_new.code != ctrl_q.code)) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
         end
      end
      if (do_push) begin
         wr_ptr_d = wr_inc;
         count_d  = count_q + CW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_inc;
         count_d  = count_q - CW'(1);
      end
      if (push_i && full_o)  ovf_d = 1'b1;
      if (pop_i && empty_o)  udf_d = 1'b1;
      if (status_we_i) begin
         if (wdata_i[ST_OVF]) ovf_d = 1'b0;
         if (wdata_i[ST_UDF]) udf_d = 1'b0;
      end
      if (thresh_we_i) begin
         af_lvl_d = wdata_i[15:0];
         ae_lvl_d = wdata_i[31:16];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ctrl_q   <= '{af_ie: 1'b0, udf_ie: 1'b0, ovf_ie: 1'b0, code: 4'd1};
         af_lvl_q <= 16'(MAX_DEPTH);
         ae_lvl_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ctrl_q   <= ctrl_d;
         af_lvl_q <= af_lvl_d;
         ae_lvl_q <= ae_lvl_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i[WIDTH-1:0];
   end

   assign head_o   = 32'(mem_q[rd_ptr_q]);
   assign thresh_o = {ae_lvl_q, af_lvl_q};
   assign ctrl_o   = {13'd0, ctrl_q.af_ie, ctrl_q.udf_ie, ctrl_q.ovf_ie, 12'd0, ctrl_q.code};
   assign irq_o    = (ovf_q & ctrl_q.ovf_ie) | (udf_q & ctrl_q.udf_ie) | (almost_full & ctrl_q.af_ie);

   always_comb begin
      status_o           = '0;
      status_o[ST_EMPTY] = empty_o;
      status_o[ST_FULL]  = full_o;
      status_o[ST_AF]    = almost_full;
      status_o[ST_AE]    = almost_empty;
      status_o[ST_OVF]   = ovf_q;
      status_o[ST_UDF]   = udf_q;
      status_o[31:16]    = 16'(count_q);
   end

endmodule

// File: rtl/apb_multi_fifo.sv
// APB4 completer fronting NUM_CH FIFO channels: decodes the register and data windows,
// muxes read data and error, and combines the per-channel interrupt terms.
module apb_multi_fifo
   import apb_multi_fifo_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_DEPTH = 256
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [31:0]       PADDR,
   input  logic [2:0]        PPROT,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PWDATA,
   input  logic [3:0]        PSTRB,
   output logic              PREADY,
   output logic [31:0]       PRDATA,
   output logic              PSLVERR,
   output logic [NUM_CH-1:0] full,
   output logic [NUM_CH-1:0] empty,
   output logic              irq
);
   localparam int LANES    = WIDTH / 8;
   localparam int MAX_CODE = $clog2(MAX_DEPTH / 4);

   logic [NUM_CH-1:0] irq_w, push_v, pop_v, ctrl_we_v, status_we_v, thresh_we_v;
   logic [31:0]       head_w [NUM_CH];
   logic [31:0]       status_w [NUM_CH];
   logic [31:0]       ctrl_w [NUM_CH];
   logic [31:0]       thresh_w [NUM_CH];
   logic [31:0]       ch_idx, sel_head, sel_status, sel_ctrl, sel_thresh, rdata;
   logic              access, data_win, strb_all, code_ok, sel_full, sel_empty, err;
   logic              push_sel, pop_sel, ctrl_sel, status_sel, thresh_sel;
   logic              unused_pprot;

   // Reset is folded in so PRDATA/PSLVERR drop the moment PRESET rises.
   assign access       = PSEL & PENABLE & ~PRESET;
   assign data_win     = PADDR[DATA_SEL_BIT];
   assign ch_idx       = data_win ? 32'(PADDR[4:2]) : 32'(PADDR[30:4]);
   assign strb_all     = (PSTRB == 4'hF);
   assign code_ok      = (PWDATA[3:0] != 4'd0) && (32'(PWDATA[3:0]) <= 32'(MAX_CODE));
   assign unused_pprot = ^PPROT;

   always_comb begin
      sel_full   = 1'b0;
      sel_empty  = 1'b0;
      sel_head   = '0;
      sel_status = '0;
      sel_ctrl   = '0;
      sel_thresh = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_idx == 32'(c)) begin
            sel_full   = full[c];
            sel_empty  = empty[c];
            sel_head   = head_w[c];
            sel_status = status_w[c];
            sel_ctrl   = ctrl_w[c];
            sel_thresh = thresh_w[c];
         end
      end

      push_sel   = 1'b0;
      pop_sel    = 1'b0;
      ctrl_sel   = 1'b0;
      status_sel = 1'b0;
      thresh_sel = 1'b0;
      err        = 1'b0;
      rdata      = '0;
      if (access) begin
         if (ch_idx >= 32'(NUM_CH)) begin
            err = 1'b1;
         end else if (data_win) begin
            if (PWRITE) begin
               if (&PSTRB[LANES-1:0]) begin
                  push_sel = 1'b1;
                  err      = sel_full;
               end else begin
                  err = 1'b1;
               end
            end else begin
               pop_sel = 1'b1;
               err     = sel_empty;
               rdata   = sel_empty ? '0 : sel_head;
            end
         end else begin
            case (PADDR[3:0])
               OFF_CTRL: begin
                  if (!PWRITE)                 rdata    = sel_ctrl;
                  else if (strb_all && code_ok) ctrl_sel = 1'b1;
                  else                         err      = 1'b1;
               end
               OFF_STATUS: begin
                  if (!PWRITE)      rdata      = sel_status;
                  else if (strb_all) status_sel = 1'b1;
                  else              err        = 1'b1;
               end
               OFF_THRESH: begin
                  if (!PWRITE)      rdata      = sel_thresh;
                  else if (strb_all) thresh_sel = 1'b1;
                  else              err        = 1'b1;
               end
               default: err = 1'b1;
            endcase
         end
      end

      push_v      = '0;
      pop_v       = '0;
      ctrl_we_v   = '0;
      status_we_v = '0;
      thresh_we_v = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_idx == 32'(c)) begin
            push_v[c]      = push_sel;
            pop_v[c]       = pop_sel;
            ctrl_we_v[c]   = ctrl_sel;
            status_we_v[c] = status_sel;
            thresh_we_v[c] = thresh_sel;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      apb_multi_fifo_ch #(
         .WIDTH     (WIDTH),
         .MAX_DEPTH (MAX_DEPTH)
      ) u_ch (
         .clk_i       (PCLK),
         .rst_i       (PRESET),
         .push_i      (push_v[g]),
         .pop_i       (pop_v[g]),
         .ctrl_we_i   (ctrl_we_v[g]),
         .status_we_i (status_we_v[g]),
         .thresh_we_i (thresh_we_v[g]),
         .wdata_i     (PWDATA),
         .full_o      (full[g]),
         .empty_o     (empty[g]),
         .irq_o       (irq_w[g]),
         .head_o      (head_w[g]),
         .status_o    (status_w[g]),
         .ctrl_o      (ctrl_w[g]),
         .thresh_o    (thresh_w[g])
      );
   end

   assign PREADY  = 1'b1;
   assign PRDATA  = rdata;
   assign PSLVERR = err;
   assign irq     = |irq_w;

endmodule

// File: tb/tb_apb_multi_fifo.sv
// Directed bench for apb_multi_fifo: a queue-based model of every channel is compared
// against the DUT each cycle, and key steps are also pinned with hand-computed literals.
module tb_apb_multi_fifo;
   localparam int NUM_CH    = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_DEPTH = 256;
   localparam int MAX_CODE  = 6;
   localparam logic [31:0] DW = 32'h8000_0000;

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b1;
   logic [31:0]       PADDR = '0;
   logic [2:0]        PPROT = '0;
   logic              PSEL = 1'b0;
   logic              PENABLE = 1'b0;
   logic              PWRITE = 1'b0;
   logic [31:0]       PWDATA = '0;
   logic [3:0]        PSTRB = '0;
   logic              PREADY;
   logic [31:0]       PRDATA;
   logic              PSLVERR;
   logic [NUM_CH-1:0] full, empty;
   logic              irq;

   always #5 PCLK = ~PCLK;

   apb_multi_fifo #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
      .full(full), .empty(empty), .irq(irq)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          chk_en    = 1'b0;
   bit          in_access = 1'b0;
   logic [31:0] exp_rd;
   bit          exp_err;

   // Model state: one queue per channel plus the programmed fields.
   logic [7:0] mq [NUM_CH][$];
   int         m_code [NUM_CH];
   int         m_af [NUM_CH];
   int         m_ae [NUM_CH];
   bit         m_ovf [NUM_CH];
   bit         m_udf [NUM_CH];
   bit         m_ovf_ie [NUM_CH];
   bit         m_udf_ie [NUM_CH];
   bit         m_af_ie [NUM_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   function automatic int m_depth(input int c);
      return 8 * (1 << (m_code[c] - 1));
   endfunction

   function automatic logic [31:0] m_status(input int c);
      int n;
      n = mq[c].size();
      return {16'(n), 10'd0, m_udf[c], m_ovf[c], n <= m_ae[c], n >= m_af[c],
              n == m_depth(c), n == 0};
   endfunction

   function automatic logic [NUM_CH-1:0] m_full();
      logic [NUM_CH-1:0] v;
      for (int c = 0; c < NUM_CH; c++) v[c] = (mq[c].size() == m_depth(c));
      return v;
   endfunction

   function automatic logic [NUM_CH-1:0] m_empty();
      logic [NUM_CH-1:0] v;
      for (int c = 0; c < NUM_CH; c++) v[c] = (mq[c].size() == 0);
      return v;
   endfunction

   function automatic logic m_irq();
      logic r;
      r = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         r |= (m_ovf[c] & m_ovf_ie[c]) | (m_udf[c] & m_udf_ie[c]) |
              ((mq[c].size() >= m_af[c]) & m_af_ie[c]);
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         mq[c].delete();
         m_code[c] = 1; m_af[c] = MAX_DEPTH; m_ae[c] = 0;
         m_ovf[c] = 0; m_udf[c] = 0;
         m_ovf_ie[c] = 0; m_udf_ie[c] = 0; m_af_ie[c] = 0;
      end
   endtask

   // Predicts PRDATA/PSLVERR of one access; with commit set it also applies the side effects.
   task automatic model_xact(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                             input logic [3:0] strb, input bit commit,
                             output logic [31:0] rd, output bit err);
      int         ch;
      int         code;
      logic [7:0] junk;
      rd  = '0;
      err = 1'b0;
      ch  = addr[31] ? int'(addr[4:2]) : int'(addr[30:4]);
      if (ch >= NUM_CH) begin
         err = 1'b1;
      end else if (addr[31]) begin
         if (wr) begin
            if (strb[0] !== 1'b1) err = 1'b1;
            else if (mq[ch].size() == m_depth(ch)) begin
               err = 1'b1;
               if (commit) m_ovf[ch] = 1'b1;
            end else if (commit) mq[ch].push_back(wd[7:0]);
         end else if (mq[ch].size() == 0) begin
            err = 1'b1;
            if (commit) m_udf[ch] = 1'b1;
         end else begin
            rd = 32'(mq[ch][0]);
            if (commit) junk = mq[ch].pop_front();
         end
      end else begin
         case (addr[3:0])
            4'h0: if (!wr) rd = {13'd0, m_af_ie[ch], m_udf_ie[ch], m_ovf_ie[ch], 12'd0, 4'(m_code[ch])};
                  else begin
                     code = int'(wd[3:0]);
                     if (strb != 4'hF || code < 1 || code > MAX_CODE) err = 1'b1;
                     else if (commit) begin
                        if (code != m_code[ch] || wd[8]) mq[ch].delete();
                        m_code[ch] = code;
                        m_ovf_ie[ch] = wd[16]; m_udf_ie[ch] = wd[17]; m_af_ie[ch] = wd[18];
                     end
                  end
            4'h4: if (!wr) rd = m_status(ch);
                  else if (strb != 4'hF) err = 1'b1;
                  else if (commit) begin
                     if (wd[4]) m_ovf[ch] = 1'b0;
                     if (wd[5]) m_udf[ch] = 1'b0;
                  end
            4'h8: if (!wr) rd = {16'(m_ae[ch]), 16'(m_af[ch])};
                  else if (strb != 4'hF) err = 1'b1;
                  else if (commit) begin
                     m_af[ch] = int'(wd[15:0]); m_ae[ch] = int'(wd[31:16]);
                  end
            default: err = 1'b1;
         endcase
      end
   endtask

   // Per-cycle comparison of all meaningful outputs against the model.
   always @(negedge PCLK) begin
      if (chk_en && !PRESET) begin
         check("full", 32'(full), 32'(m_full()));
         check("empty", 32'(empty), 32'(m_empty()));
         check("irq", 32'(irq), 32'(m_irq()));
         check("pready", 32'(PREADY), 32'h1);
         if (in_access) begin
            check("prdata", PRDATA, exp_rd);
            check("pslverr", 32'(PSLVERR), 32'(exp_err));
         end else begin
            check("prdata_idle", PRDATA, 32'h0);
            check("pslverr_idle", 32'(PSLVERR), 32'h0);
         end
      end
   end

   task automatic apb(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                      input logic [3:0] strb, output logic [31:0] rd, output bit err);
      logic [31:0] d_rd;
      bit          d_err;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = strb;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      model_xact(addr, wr, wd, strb, 1'b0, exp_rd, exp_err);
      in_access = 1'b1;
      @(negedge PCLK);
      rd  = PRDATA;
      err = PSLVERR;
      @(posedge PCLK);
      model_xact(addr, wr, wd, strb, 1'b1, d_rd, d_err);
      in_access = 1'b0;
      #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // One access with hand-computed expected read data and error.
   task automatic xfer(input string name, input logic [31:0] addr, input bit wr,
                       input logic [31:0] wd, input logic [3:0] strb,
                       input logic [31:0] want_rd, input bit want_err);
      logic [31:0] rd;
      bit          err;
      apb(addr, wr, wd, strb, rd, err);
      check({name, ".rd"}, rd, want_rd);
      check({name, ".err"}, 32'(err), 32'(want_err));
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish within 500 us");
      $fatal(1);
   end

   initial begin
      int nxt_push, nxt_pop;
      model_reset();
      repeat (3) @(posedge PCLK);
      @(negedge PCLK) PRESET = 1'b0;
      @(posedge PCLK); #1;
      chk_en = 1'b1;

      // Reset state.
      xfer("rst_status0", 32'h04, 0, 0, 4'hF, 32'h0000_0009, 0);
      xfer("rst_ctrl0",   32'h00, 0, 0, 4'hF, 32'h0000_0001, 0);
      xfer("rst_thresh0", 32'h08, 0, 0, 4'hF, 32'h0000_0100, 0);

      // Channel 1: fill to depth 8, overflow, drain, underflow.
      xfer("ch1_ctrl", 32'h10, 1, 32'h1, 4'hF, 0, 0);
      for (int i = 0; i < 8; i++)
         xfer("ch1_push", (i == 3) ? 32'hC000_0024 : DW | 32'h4, 1, 32'h11 + i, 4'hF, 0, 0);
      xfer("ch1_push_strb", DW | 32'h4, 1, 32'h99, 4'h0, 0, 1);
      xfer("ch1_push9", DW | 32'h4, 1, 32'h19, 4'hF, 0, 1);
      check("ch1_full", 32'(full[1]), 32'h1);
      xfer("ch1_status_ovf", 32'h14, 0, 0, 4'hF, 32'h0008_0012, 0);
      for (int i = 0; i < 8; i++)
         xfer("ch1_pop", DW | 32'h4, 0, 0, 4'hF, 32'h11 + i, 0);
      xfer("ch1_pop9", DW | 32'h4, 0, 0, 4'hF, 32'h0, 1);
      xfer("ch1_status_udf", 32'h14, 0, 0, 4'hF, 32'h0000_0039, 0);

      // Channel 2: depth 16, order preserved across the pointer wrap.
      xfer("ch2_ctrl", 32'h20, 1, 32'h2, 4'hF, 0, 0);
      nxt_push = 0; nxt_pop = 0;
      for (int i = 0; i < 12; i++) begin
         xfer("ch2_push", DW | 32'h8, 1, 32'h40 + nxt_push, 4'hF, 0, 0);
         nxt_push++;
      end
      for (int i = 0; i < 8; i++) begin
         xfer("ch2_push_w", DW | 32'h8, 1, 32'h40 + nxt_push, 4'hF, 0, 0);
         nxt_push++;
         xfer("ch2_pop_w", DW | 32'h8, 0, 0, 4'hF, 32'h40 + nxt_pop, 0);
         nxt_pop++;
      end
      xfer("ch2_status", 32'h24, 0, 0, 4'hF, 32'h000C_0000, 0);
      for (int i = 0; i < 12; i++) begin
         xfer("ch2_pop", DW | 32'h8, 0, 0, 4'hF, 32'h40 + nxt_pop, 0);
         nxt_pop++;
      end

      // Illegal accesses leave state untouched.
      xfer("ch0_ctrl_code0", 32'h00, 1, 32'h0, 4'hF, 0, 1);
      xfer("ch0_ctrl_code7", 32'h00, 1, 32'h7, 4'hF, 0, 1);
      xfer("ch0_ctrl_strb",  32'h00, 1, 32'h2, 4'h7, 0, 1);
      xfer("ch0_ctrl_kept",  32'h00, 0, 0, 4'hF, 32'h0000_0001, 0);
      xfer("off_c",          32'h0C, 0, 0, 4'hF, 0, 1);
      xfer("ch5_reg",        32'h54, 0, 0, 4'hF, 0, 1);
      xfer("ch6_data",       DW | 32'h18, 1, 32'h1, 4'hF, 0, 1);

      // Channel 3: almost-full interrupt, then STATUS W1C on channel 1.
      xfer("ch3_thresh", 32'h38, 1, 32'h0000_0004, 4'hF, 0, 0);
      xfer("ch3_ctrl",   32'h30, 1, 32'h0004_0001, 4'hF, 0, 0);
      xfer("ch3_ctrl_rd", 32'h30, 0, 0, 4'hF, 32'h0004_0001, 0);
      for (int i = 0; i < 3; i++) xfer("ch3_push", DW | 32'hC, 1, 32'hA0 + i, 4'hF, 0, 0);
      check("ch3_irq_low", 32'(irq), 32'h0);
      xfer("ch3_push4", DW | 32'hC, 1, 32'hA3, 4'hF, 0, 0);
      @(negedge PCLK);
      check("ch3_irq_high", 32'(irq), 32'h1);
      @(posedge PCLK); #1;
      xfer("ch1_w1c_ovf", 32'h14, 1, 32'h0000_0010, 4'hF, 0, 0);
      xfer("ch1_st_a",    32'h14, 0, 0, 4'hF, 32'h0000_0029, 0);
      xfer("ch1_w1c_udf", 32'h14, 1, 32'h0000_0020, 4'hF, 0, 0);
      xfer("ch1_st_b",    32'h14, 0, 0, 4'hF, 32'h0000_0009, 0);

      // Reset asserted in the middle of an access phase.
      for (int i = 0; i < 5; i++) xfer("ch0_push", DW, 1, 32'h60 + i, 4'hF, 0, 0);
      chk_en = 1'b0;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h04; PWRITE = 1'b0; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #2;
      PRESET = 1'b1;
      #1;
      check("rst_full",    32'(full), 32'h0);
      check("rst_empty",   32'(empty), 32'hF);
      check("rst_irq",     32'(irq), 32'h0);
      check("rst_prdata",  PRDATA, 32'h0);
      check("rst_pslverr", 32'(PSLVERR), 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0;
      model_reset();
      @(negedge PCLK) PRESET = 1'b0;
      @(posedge PCLK); #1;
      chk_en = 1'b1;
      xfer("post_rst_status0", 32'h04, 0, 0, 4'hF, 32'h0000_0009, 0);
      xfer("post_rst_pop0",    DW, 0, 0, 4'hF, 32'h0, 1);

      @(posedge PCLK); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
